// File: rtl/idma_pkg.sv
// Shared iDMA types: error-handler actions, error types, busy flags and the
// error-queue entry layout used by the error-handling arbiter.
package idma_pkg;

  typedef enum logic [1:0] {
    BUS_READ  = 2'd0,
    BUS_WRITE = 2'd1,
    BACKEND   = 2'd2,
    ND_MIDEND = 2'd3
  } err_type_e;

  typedef enum logic {
    CONTINUE = 1'b0,
    ABORT    = 1'b1
  } eh_action_e;

  typedef logic idma_eh_req_t;

  typedef struct packed {
    logic buffer_busy;
    logic r_dp_busy;
    logic w_dp_busy;
    logic r_leg_busy;
    logic w_leg_busy;
    logic eh_fsm_busy;
    logic eh_cnt_busy;
    logic raw_coupler_busy;
  } idma_busy_t;

  localparam int unsigned EhDefaultAddrWidth   = 64;
  localparam int unsigned EhDefaultChanIdWidth = 2;

  // Default-width view of a queued error; modules re-declare it locally with their own widths.
  typedef struct packed {
    err_type_e                         err_type;
    logic [EhDefaultAddrWidth-1:0]     addr;
    logic [EhDefaultChanIdWidth-1:0]   chan;
  } idma_eh_entry_t;

  typedef enum logic [1:0] {
    EH_IDLE,
    EH_REPORT,
    EH_WAIT_ACT,
    EH_DELIVER
  } eh_state_e;

  function automatic int unsigned eh_chan_id_width(input int unsigned num_channels);
    return (num_channels > 1) ? $clog2(num_channels) : 1;
  endfunction

endpackage

// File: rtl/idma_eh_queue.sv
// Synchronous-reset FIFO holding pending error entries, with full/empty/count.
module idma_eh_queue #(
  parameter int unsigned Depth      = 4,
  parameter type         entry_t    = logic,
  parameter int unsigned CountWidth = $clog2(Depth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  entry_t                data_i,
  input  logic                  pop_i,
  output entry_t                head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CountWidth-1:0] count_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

  entry_t                mem_q [Depth];
  entry_t                mem_d [Depth];
  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic                  do_push, do_pop;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
    return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full_o  = (count_q == CountWidth'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/idma_eh_arbiter.sv
// Multi-channel error handler: round-robin intake of channel errors into a queue,
// one-at-a-time reporting to the frontend and routing of its action back to the channel.
module idma_eh_arbiter
  import idma_pkg::*;
#(
  parameter int unsigned NumChannels = 4,
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned QueueDepth  = 4,
  parameter int unsigned CntWidth    = 16,
  parameter int unsigned ChanIdWidth = eh_chan_id_width(NumChannels)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumChannels-1:0]                err_valid_i,
  output logic [NumChannels-1:0]                err_ready_o,
  input  logic [NumChannels-1:0][1:0]           err_type_i,
  input  logic [NumChannels-1:0][AddrWidth-1:0] err_addr_i,
  output logic [NumChannels-1:0]                act_valid_o,
  output logic                                  act_o,
  input  logic [NumChannels-1:0]                act_ready_i,
  output logic                                  rep_valid_o,
  input  logic                                  rep_ready_i,
  output logic [1:0]                            rep_type_o,
  output logic [AddrWidth-1:0]                  rep_addr_o,
  output logic [ChanIdWidth-1:0]                rep_chan_o,
  input  logic                                  eh_valid_i,
  output logic                                  eh_ready_o,
  input  idma_eh_req_t                          eh_i,
  input  logic                                  cnt_clear_i,
  output logic [3:0][CntWidth-1:0]              err_cnt_o,
  output logic                                  eh_fsm_busy_o,
  output logic                                  eh_cnt_busy_o
);

  localparam int unsigned QCntWidth = $clog2(QueueDepth + 1);

  typedef struct packed {
    err_type_e              err_type;
    logic [AddrWidth-1:0]   addr;
    logic [ChanIdWidth-1:0] chan;
  } eh_entry_t;

  eh_state_e                 state_q, state_d;
  eh_action_e                act_q, act_d;
  logic [NumChannels-1:0]    outstanding_q, outstanding_d;
  logic [ChanIdWidth-1:0]    rr_q, rr_d;
  logic [3:0][CntWidth-1:0]  cnt_q, cnt_d;

  logic [NumChannels-1:0]    req;
  logic                      grant_valid;
  logic [ChanIdWidth-1:0]    grant_idx, cand_idx;
  int unsigned               cand;
  logic                      push, pop, q_full, q_empty;
  logic [QCntWidth-1:0]      q_count;
  eh_entry_t                 push_entry, head;

  // Round-robin search starting at rr_q over channels without an error in flight.
  always_comb begin
    req         = err_valid_i & ~outstanding_q;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int unsigned k = 0; k < NumChannels; k++) begin
      cand     = (32'(rr_q) + k) % NumChannels;
      cand_idx = ChanIdWidth'(cand);
      if (!grant_valid && req[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Full is the registered count, so a same-cycle pop never opens intake.
  assign push        = grant_valid & ~q_full & ~rst_i;
  assign err_ready_o = push ? (NumChannels'(1) << grant_idx) : '0;

  always_comb begin
    push_entry          = '0;
    push_entry.err_type = err_type_e'(err_type_i[grant_idx]);
    push_entry.addr     = err_addr_i[grant_idx];
    push_entry.chan     = grant_idx;
  end

  idma_eh_queue #(
    .Depth      (QueueDepth),
    .entry_t    (eh_entry_t),
    .CountWidth (QCntWidth)
  ) i_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    pop         = 1'b0;
    rep_valid_o = 1'b0;
    eh_ready_o  = 1'b0;
    act_valid_o = '0;
    unique case (state_q)
      EH_IDLE: begin
        if (!q_empty) state_d = EH_REPORT;
      end
      EH_REPORT: begin
        rep_valid_o = 1'b1;
        if (rep_ready_i) state_d = EH_WAIT_ACT;
      end
      EH_WAIT_ACT: begin
        eh_ready_o = 1'b1;
        if (eh_valid_i) begin
          act_d   = eh_action_e'(eh_i);
          state_d = EH_DELIVER;
        end
      end
      EH_DELIVER: begin
        act_valid_o[head.chan] = 1'b1;
        if (act_ready_i[head.chan]) begin
          pop     = 1'b1;
          state_d = ((q_count != QCntWidth'(1)) || push) ? EH_REPORT : EH_IDLE;
        end
      end
      default: state_d = EH_IDLE;
    endcase
  end

  always_comb begin
    outstanding_d = outstanding_q;
    rr_d          = rr_q;
    if (pop) outstanding_d[head.chan] = 1'b0;
    if (push) begin
      outstanding_d[grant_idx] = 1'b1;
      rr_d = (grant_idx == ChanIdWidth'(NumChannels - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // A clear coinciding with a push leaves only the pushed type at one.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clear_i) cnt_d = '0;
    if (push) begin
      if (cnt_clear_i) begin
        cnt_d[push_entry.err_type] = CntWidth'(1);
      end else if (cnt_q[push_entry.err_type] != '1) begin
        cnt_d[push_entry.err_type] = cnt_q[push_entry.err_type] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= EH_IDLE;
      act_q         <= CONTINUE;
      outstanding_q <= '0;
      rr_q          <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      act_q         <= act_d;
      outstanding_q <= outstanding_d;
      rr_q          <= rr_d;
      cnt_q         <= cnt_d;
    end
  end

  assign rep_type_o    = rep_valid_o ? head.err_type : 2'b00;
  assign rep_addr_o    = rep_valid_o ? head.addr : '0;
  assign rep_chan_o    = rep_valid_o ? head.chan : '0;
  assign act_o         = act_q;
  assign err_cnt_o     = cnt_q;
  assign eh_fsm_busy_o = (state_q != EH_IDLE);
  assign eh_cnt_busy_o = ~q_empty | (|outstanding_q);

endmodule

// File: tb/tb_idma_eh_arbiter.sv
// Directed bench for idma_eh_arbiter: single error, round-robin with a full
// queue, outstanding blocking, reset mid-operation and counter saturation/clear.
module tb_idma_eh_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        errValid;
  logic [3:0]        errReady;
  logic [3:0][1:0]   errType;
  logic [3:0][63:0]  errAddr;
  logic [3:0]        actValid;
  logic              actOut;
  logic [3:0]        actReady;
  logic              repValid, repReady;
  logic [1:0]        repType;
  logic [63:0]       repAddr;
  logic [1:0]        repChan;
  logic              ehValid, ehReady, ehAct;
  logic              cntClear;
  logic [3:0][1:0]   errCnt;
  logic              fsmBusy, cntBusy;

  logic [3:0]        holdMask;
  int                acceptLog[$];
  int                compareCount = 0;
  int                mismatchCount = 0;

  always #5 clk = ~clk;

  idma_eh_arbiter #(
    .NumChannels (4),
    .AddrWidth   (64),
    .QueueDepth  (2),
    .CntWidth    (2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .err_valid_i   (errValid),
    .err_ready_o   (errReady),
    .err_type_i    (errType),
    .err_addr_i    (errAddr),
    .act_valid_o   (actValid),
    .act_o         (actOut),
    .act_ready_i   (actReady),
    .rep_valid_o   (repValid),
    .rep_ready_i   (repReady),
    .rep_type_o    (repType),
    .rep_addr_o    (repAddr),
    .rep_chan_o    (repChan),
    .eh_valid_i    (ehValid),
    .eh_ready_o    (ehReady),
    .eh_i          (ehAct),
    .cnt_clear_i   (cntClear),
    .err_cnt_o     (errCnt),
    .eh_fsm_busy_o (fsmBusy),
    .eh_cnt_busy_o (cntBusy)
  );

  // Every comparison goes through here so the summary counts stay honest.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic v, input logic [1:0] t, input logic [63:0] a);
    errValid[ch] = v;
    errType[ch]  = t;
    errAddr[ch]  = a;
  endtask

  task automatic settle();
    #1;
  endtask

  // Advance one cycle; channels drop their request once accepted unless held.
  task automatic tick();
    logic [3:0] accepted;
    #1;
    accepted = errValid & errReady;
    for (int i = 0; i < 4; i++) begin
      if (accepted[i]) acceptLog.push_back(i);
    end
    @(posedge clk);
    #1;
    errValid = errValid & ~(accepted & ~holdMask);
  endtask

  task automatic resetDut();
    rst      = 1'b1;
    errValid = '0;
    errType  = '0;
    errAddr  = '0;
    actReady = '0;
    repReady = 1'b0;
    ehValid  = 1'b0;
    ehAct    = 1'b0;
    cntClear = 1'b0;
    holdMask = '0;
    tick();
    tick();
    rst = 1'b0;
    acceptLog.delete();
  endtask

  // Walks one queued error through report, action and delivery; starts in the REPORT cycle.
  task automatic serviceOne(input int chan, input logic [63:0] addr, input logic [1:0] typ,
                            input logic action, input logic [3:0] readyAtPop);
    settle();
    checkOutput($sformatf("rep_valid_ch%0d", chan), 64'(repValid), 64'(1));
    checkOutput($sformatf("rep_chan_ch%0d", chan), 64'(repChan), 64'(chan));
    checkOutput($sformatf("rep_addr_ch%0d", chan), repAddr, addr);
    checkOutput($sformatf("rep_type_ch%0d", chan), 64'(repType), 64'(typ));
    checkOutput($sformatf("fsm_busy_rep_ch%0d", chan), 64'(fsmBusy), 64'(1));
    repReady = 1'b1;
    tick();
    repReady = 1'b0;
    settle();
    checkOutput($sformatf("eh_ready_ch%0d", chan), 64'(ehReady), 64'(1));
    checkOutput($sformatf("rep_valid_wait_ch%0d", chan), 64'(repValid), 64'(0));
    ehValid = 1'b1;
    ehAct   = action;
    tick();
    ehValid = 1'b0;
    settle();
    checkOutput($sformatf("act_valid_ch%0d", chan), 64'(actValid), 64'(4'b0001 << chan));
    checkOutput($sformatf("act_o_ch%0d", chan), 64'(actOut), 64'(action));
    checkOutput($sformatf("eh_ready_dlv_ch%0d", chan), 64'(ehReady), 64'(0));
    checkOutput($sformatf("ready_at_pop_ch%0d", chan), 64'(errReady), 64'(readyAtPop));
    actReady = 4'b0001 << chan;
    tick();
    actReady = '0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetDut();
    rst = 1'b1;
    settle();
    checkOutput("rst_err_ready", 64'(errReady), 64'(0));
    checkOutput("rst_rep_valid", 64'(repValid), 64'(0));
    checkOutput("rst_act_valid", 64'(actValid), 64'(0));
    checkOutput("rst_eh_ready", 64'(ehReady), 64'(0));
    checkOutput("rst_err_cnt", 64'(errCnt), 64'(0));
    checkOutput("rst_busy", 64'({fsmBusy, cntBusy}), 64'(0));
    resetDut();

    // Single error: ch2 BUS_WRITE at 0x1000, answered with ABORT.
    applyStimulus(2, 1'b1, 2'd1, 64'h1000);
    settle();
    checkOutput("t1_err_ready", 64'(errReady), 64'(4'b0100));
    tick();
    settle();
    checkOutput("t1_rep_early", 64'(repValid), 64'(0));
    checkOutput("t1_cnt_bus_write", 64'(errCnt[1]), 64'(1));
    checkOutput("t1_cnt_busy", 64'(cntBusy), 64'(1));
    checkOutput("t1_fsm_idle", 64'(fsmBusy), 64'(0));
    tick();
    serviceOne(2, 64'h1000, 2'd1, 1'b1, 4'b0000);
    settle();
    checkOutput("t1_idle_after", 64'({fsmBusy, cntBusy}), 64'(0));
    checkOutput("t1_act_valid_off", 64'(actValid), 64'(0));

    // Round-robin with a two-entry queue: ch2 must wait for the first pop.
    resetDut();
    applyStimulus(0, 1'b1, 2'd2, 64'hA000);
    applyStimulus(1, 1'b1, 2'd0, 64'hA001);
    applyStimulus(2, 1'b1, 2'd1, 64'hA002);
    applyStimulus(3, 1'b1, 2'd0, 64'hA003);
    settle();
    checkOutput("rr_grant0", 64'(errReady), 64'(4'b0001));
    tick();
    settle();
    checkOutput("rr_grant1", 64'(errReady), 64'(4'b0010));
    tick();
    settle();
    checkOutput("rr_full", 64'(errReady), 64'(0));
    serviceOne(0, 64'hA000, 2'd2, 1'b0, 4'b0000);
    settle();
    checkOutput("rr_after_pop", 64'(errReady), 64'(4'b0100));
    serviceOne(1, 64'hA001, 2'd0, 1'b1, 4'b0000);
    settle();
    checkOutput("rr_ch3_grant", 64'(errReady), 64'(4'b1000));
    serviceOne(2, 64'hA002, 2'd1, 1'b0, 4'b0000);
    serviceOne(3, 64'hA003, 2'd0, 1'b1, 4'b0000);
    settle();
    checkOutput("rr_busy_clear", 64'({fsmBusy, cntBusy}), 64'(0));
    checkOutput("rr_accept_count", 64'(acceptLog.size()), 64'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < acceptLog.size()) checkOutput($sformatf("rr_order%0d", i), 64'(acceptLog[i]), 64'(i));
    end
    checkOutput("rr_cnt_all", 64'(errCnt), 64'({2'd0, 2'd1, 2'd1, 2'd2}));

    // Outstanding block, then reset while waiting for the frontend action.
    resetDut();
    holdMask = 4'b0010;
    applyStimulus(1, 1'b1, 2'd2, 64'h2000);
    settle();
    checkOutput("ob_accept", 64'(errReady), 64'(4'b0010));
    tick();
    settle();
    checkOutput("ob_blocked1", 64'(errReady), 64'(0));
    tick();
    settle();
    checkOutput("ob_blocked2", 64'(errReady), 64'(0));
    serviceOne(1, 64'h2000, 2'd2, 1'b1, 4'b0000);
    settle();
    checkOutput("ob_reaccept", 64'(errReady), 64'(4'b0010));
    tick();
    checkOutput("ob_accept_count", 64'(acceptLog.size()), 64'(2));
    settle();
    checkOutput("ob_rep_early", 64'(repValid), 64'(0));
    tick();
    settle();
    checkOutput("ob_rep_valid", 64'(repValid), 64'(1));
    repReady = 1'b1;
    tick();
    repReady = 1'b0;
    settle();
    checkOutput("ob_wait_act", 64'(ehReady), 64'(1));
    rst = 1'b1;
    tick();
    settle();
    checkOutput("mid_rst_err_ready", 64'(errReady), 64'(0));
    checkOutput("mid_rst_handshakes", 64'({repValid, ehReady, actValid}), 64'(0));
    checkOutput("mid_rst_act_o", 64'(actOut), 64'(0));
    checkOutput("mid_rst_rep_addr", repAddr, 64'(0));
    checkOutput("mid_rst_busy", 64'({fsmBusy, cntBusy}), 64'(0));
    checkOutput("mid_rst_cnt", 64'(errCnt), 64'(0));
    rst = 1'b0;
    settle();
    checkOutput("mid_rst_reaccept", 64'(errReady), 64'(4'b0010));
    holdMask = '0;
    tick();
    tick();
    serviceOne(1, 64'h2000, 2'd2, 1'b1, 4'b0000);

    // Counter saturation at 3 with CntWidth=2, then clear alongside a BACKEND push.
    resetDut();
    for (int r = 1; r <= 5; r++) begin
      applyStimulus(0, 1'b1, 2'd0, 64'h3000 + 64'(r));
      tick();
      settle();
      checkOutput($sformatf("cnt_bus_read_r%0d", r), 64'(errCnt[0]), 64'((r > 3) ? 3 : r));
      tick();
      serviceOne(0, 64'h3000 + 64'(r), 2'd0, 1'b0, 4'b0000);
    end
    applyStimulus(0, 1'b1, 2'd2, 64'h4000);
    cntClear = 1'b1;
    settle();
    checkOutput("clr_push_ready", 64'(errReady), 64'(4'b0001));
    tick();
    cntClear = 1'b0;
    settle();
    checkOutput("clr_bus_read", 64'(errCnt[0]), 64'(0));
    checkOutput("clr_backend", 64'(errCnt[2]), 64'(1));
    checkOutput("clr_others", 64'({errCnt[3], errCnt[1]}), 64'(0));
    tick();
    serviceOne(0, 64'h4000, 2'd2, 1'b0, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
